// File: rtl/student_fir_out_stage_if.sv
// student_fir_out_stage_if: bundles the FIR-result input side and the
// sample stream / status outputs of the FIR output stage.
// The slave modport is the output stage itself. The master modport is
// the surrounding logic: it drives strobes and ready and reads samples
// and status.
interface student_fir_out_stage_if #(
    parameter int DATA_SIZE         = 16,
    parameter int DATA_SIZE_FIR_OUT = 32,
    parameter int FIFO_DEPTH        = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                         valid_strobe_i;
    logic [DATA_SIZE_FIR_OUT-1:0] y_i;
    logic                         clear_i;
    logic [DATA_SIZE-1:0]         sample_o;
    logic                         valid_o;
    logic                         ready_i;
    logic [LVL_W-1:0]             level_o;
    logic                         overflow_o;
    logic [15:0]                  drop_cnt_o;

    modport slave (
        input  valid_strobe_i, y_i, clear_i, ready_i,
        output sample_o, valid_o, level_o, overflow_o, drop_cnt_o
    );

    modport master (
        output valid_strobe_i, y_i, clear_i, ready_i,
        input  sample_o, valid_o, level_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/student_fir_out_stage.sv
// student_fir_out_stage: takes the FIR accumulator on a strobe edge and
// processes it through two pipeline stages. It applies round-half-up and
// an arithmetic shift by FRAC_SHIFT, narrows the result to DATA_SIZE, and
// queues it in a small FIFO that has a valid/ready output. When the FIFO
// is full, new results are dropped. A sticky flag and a saturating
// counter record these drops.
// Optional build macro STUDENT_FIR_OUT_SAT_EN clamps the narrowed result.
// Without the macro, the narrowed result wraps (low DATA_SIZE bits).
module student_fir_out_stage #(
    parameter int DATA_SIZE         = 16,
    parameter int DATA_SIZE_FIR_OUT = 32,
    parameter int FRAC_SHIFT        = 15,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    student_fir_out_stage_if.slave    bus
);
    localparam int STAGES = 1;                    // vld_pipe index of last stage
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PW     = AW + 1;               // extra bit tells full from empty
    localparam int SUM_W  = DATA_SIZE_FIR_OUT + 1;

    localparam logic [SUM_W-1:0] RND_HALF =
        {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

    // ------------------------------------------------------------------
    // Strobe edge detect and pipeline valids
    // ------------------------------------------------------------------
    logic              strb_prev_q;
    logic              strb_det;
    logic [STAGES:0]   vld_pipe_q;   // [0] stage-1 holds data, [1] stage-2 holds data

    assign strb_det = bus.valid_strobe_i & ~strb_prev_q;

    // The previous-value register comes out of reset as 1. Because of
    // this, a strobe that is already high at release does not count as
    // an event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            strb_prev_q <= 1'b1;
            vld_pipe_q  <= '0;
        end else begin
            strb_prev_q <= bus.valid_strobe_i;
            vld_pipe_q  <= {vld_pipe_q[STAGES-1:0], strb_det};
        end
    end

    // ------------------------------------------------------------------
    // Data stages (no reset needed, qualified by vld_pipe_q)
    // ------------------------------------------------------------------
    logic [DATA_SIZE_FIR_OUT-1:0] s1_q;
    logic [DATA_SIZE-1:0]         s2_q;
    logic [DATA_SIZE-1:0]         s2_d;
    logic [SUM_W-1:0]             rnd_sum;
    logic signed [SUM_W-1:0]      shifted;

    // Round half up in one extra bit so that adding the half LSB to the
    // most positive accumulator cannot overflow.
    always_comb begin
        rnd_sum = {s1_q[DATA_SIZE_FIR_OUT-1], s1_q} + RND_HALF;
        shifted = $signed(rnd_sum) >>> FRAC_SHIFT;
    end

`ifdef STUDENT_FIR_OUT_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        $signed({{(SUM_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        $signed({{(SUM_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}});

    // Clamp the shifted value into the signed DATA_SIZE range
    always_comb begin
        s2_d = DATA_SIZE'(shifted);
        if (shifted > SAT_MAX)
            s2_d = {1'b0, {(DATA_SIZE-1){1'b1}}};
        else if (shifted < SAT_MIN)
            s2_d = {1'b1, {(DATA_SIZE-1){1'b0}}};
    end
`else
    // Keep the low DATA_SIZE bits of the shifted value (wrap)
    always_comb begin
        s2_d = DATA_SIZE'(shifted);
    end
`endif

    // Capture the accumulator on the detect edge, then the narrowed result one edge later
    always_ff @(posedge clk_i) begin
        if (strb_det)
            s1_q <= bus.y_i;
        if (vld_pipe_q[0])
            s2_q <= s2_d;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic                 empty, full;
    logic                 push_req, push_ok, pop, drop;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign push_req = vld_pipe_q[STAGES];
    assign pop      = ~empty & bus.ready_i;
    // If the FIFO is full, a pop on the same edge frees a slot, so the push can still go in.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // Pointer next state
    always_comb begin
        wptr_d = wptr_q + PW'(push_ok);
        rptr_d = rptr_q + PW'(pop);
    end

    // Pointer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write. On a full-FIFO push with pop, the write slot is the
    // slot being read. The head is read combinationally before the edge,
    // so it is not lost.
    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wptr_q[AW-1:0]] <= s2_q;
    end

    assign bus.sample_o = mem_q[rptr_q[AW-1:0]];
    assign bus.valid_o  = ~empty;
    assign bus.level_o  = wptr_q - rptr_q;

    // ------------------------------------------------------------------
    // Drop status
    // ------------------------------------------------------------------
    logic        overflow_q, overflow_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // clear_i wins over a drop on the same edge; the counter stops at all-ones
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.clear_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF)
                drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.overflow_o = overflow_q;
    assign bus.drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_student_fir_out_stage.sv
// tb_student_fir_out_stage: drives strobes into the FIR output stage and
// checks the results with a scoreboard.
// Expected samples are queued when a strobe is driven. They are popped and
// compared whenever the DUT hands a sample to the consumer.
module tb_student_fir_out_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [15:0] sb[$];

    student_fir_out_stage_if #(.DATA_SIZE(16), .DATA_SIZE_FIR_OUT(32), .FIFO_DEPTH(8)) bus ();

    student_fir_out_stage #(
        .DATA_SIZE(16), .DATA_SIZE_FIR_OUT(32), .FRAC_SHIFT(15), .FIFO_DEPTH(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: round half up, shift by 15, then clamp or wrap to 16 bits
    function automatic logic [15:0] model(input logic [31:0] y);
        longint s;
        s = longint'($signed(y)) + 64'sd16384;
        s = s >>> 15;
`ifdef STUDENT_FIR_OUT_SAT_EN
        if (s > 64'sd32767)
            s = 64'sd32767;
        else if (s < -64'sd32768)
            s = -64'sd32768;
`endif
        return s[15:0];
    endfunction

    // Advance one cycle. At the negedge, consume a handshake against the scoreboard.
    task automatic tick();
        logic [15:0] exp;
        @(negedge clk);
        if (!rst && bus.valid_o && bus.ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got %h expected none", bus.sample_o);
            end else begin
                exp = sb.pop_front();
                if (bus.sample_o !== exp) begin
                    errors++;
                    $display("FAIL pop_data got %h expected %h", bus.sample_o, exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One strobe pulse. The detect edge is the first edge. The task returns 1ns after the edge that follows it.
    task automatic drive_strobe(input logic [31:0] v, input bit exp_en, input logic [15:0] exp);
        bus.valid_strobe_i = 1'b1;
        bus.y_i = v;
        if (exp_en) sb.push_back(exp);
        tick();
        bus.valid_strobe_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_strobe_i = 1'b0;
        bus.y_i = '0;
        bus.clear_i = 1'b0;
        bus.ready_i = 1'b0;
        #12;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b expected 0", bus.valid_o); end
        checks++; if (bus.level_o !== 4'd0) begin errors++; $display("FAIL rst_level got %0d expected 0", bus.level_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b expected 0", bus.overflow_o); end
        checks++; if (bus.drop_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d expected 0", bus.drop_cnt_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bus.ready_i = 1'b1;
        drive_strobe(32'h0000_4000, 1'b1, 16'h0001);
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL basic_e1_valid got %b expected 0", bus.valid_o); end
        tick();
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL basic_e2_valid got %b expected 1", bus.valid_o); end
        checks++; if (bus.sample_o !== 16'h0001) begin errors++; $display("FAIL basic_sample got %h expected 0001", bus.sample_o); end
        checks++; if (bus.level_o !== 4'd1) begin errors++; $display("FAIL basic_level got %0d expected 1", bus.level_o); end
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL basic_e3_valid got %b expected 0", bus.valid_o); end
    endtask

    task automatic test_rounding();
        logic [31:0] v;
        bus.ready_i = 1'b1;
`ifdef STUDENT_FIR_OUT_SAT_EN
        drive_strobe(32'h3FFF_FFFF, 1'b1, 16'h7FFF);
        drive_strobe(32'hC000_0000, 1'b1, 16'h8000);
        drive_strobe(32'h7FFF_FFFF, 1'b1, 16'h7FFF);
        drive_strobe(32'h8000_0000, 1'b1, 16'h8000);
`else
        drive_strobe(32'h3FFF_FFFF, 1'b1, 16'h8000);
        drive_strobe(32'hC000_0000, 1'b1, 16'h8000);
        drive_strobe(32'h7FFF_FFFF, 1'b1, 16'h0000);
        drive_strobe(32'h8000_0000, 1'b1, 16'h0000);
`endif
        drive_strobe(32'hFFFF_C000, 1'b1, 16'h0000);
        drive_strobe(32'hFFFF_BFFF, 1'b1, 16'hFFFF);
        drive_strobe(32'h0000_3FFF, 1'b1, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            drive_strobe(v, 1'b1, model(v));
        end
        repeat (4) tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL round_drain got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 12; i++) begin
            bus.ready_i = (i % 4) != 0;
            v = {$urandom_range(0, 65535), 16'h0000} - 32'h4000_0000;
            drive_strobe(v, 1'b1, model(v));
        end
        // A strobe held high for several cycles must produce a single sample
        bus.ready_i = 1'b1;
        bus.valid_strobe_i = 1'b1;
        bus.y_i = 32'd7 << 15;
        sb.push_back(16'd7);
        repeat (4) tick();
        bus.valid_strobe_i = 1'b0;
        repeat (6) tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d left expected 0", sb.size()); end
        checks++; if (bus.level_o !== 4'd0) begin errors++; $display("FAIL b2b_level got %0d expected 0", bus.level_o); end
    endtask

    task automatic test_overflow();
        bus.ready_i = 1'b0;
        for (int k = 1; k <= 10; k++)
            drive_strobe(32'(k) << 15, k <= 8, 16'(k));
        repeat (2) tick();
        checks++; if (bus.level_o !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d expected 8", bus.level_o); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b expected 1", bus.overflow_o); end
        checks++; if (bus.drop_cnt_o !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d expected 2", bus.drop_cnt_o); end
    endtask

    task automatic test_full_pushpop_clear();
        // The push into the full FIFO and the pop land on the same edge
        drive_strobe(32'd11 << 15, 1'b1, 16'd11);
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        checks++; if (bus.level_o !== 4'd8) begin errors++; $display("FAIL pp_level got %0d expected 8", bus.level_o); end
        checks++; if (bus.drop_cnt_o !== 16'd2) begin errors++; $display("FAIL pp_drop got %0d expected 2", bus.drop_cnt_o); end
        // Clear on the same edge as a drop
        drive_strobe(32'd12 << 15, 1'b0, 16'd0);
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL clrprio_flag got %b expected 0", bus.overflow_o); end
        checks++; if (bus.drop_cnt_o !== 16'd0) begin errors++; $display("FAIL clrprio_drop got %0d expected 0", bus.drop_cnt_o); end
        drive_strobe(32'd13 << 15, 1'b0, 16'd0);
        tick();
        checks++; if (bus.drop_cnt_o !== 16'd1) begin errors++; $display("FAIL drop_again got %0d expected 1", bus.drop_cnt_o); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL drop_again_flag got %b expected 1", bus.overflow_o); end
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL clr_flag got %b expected 0", bus.overflow_o); end
        checks++; if (bus.drop_cnt_o !== 16'd0) begin errors++; $display("FAIL clr_drop got %0d expected 0", bus.drop_cnt_o); end
        // Drain: expected order is 2..8 and then 11
        bus.ready_i = 1'b1;
        for (int i = 0; i < 40 && (sb.size() != 0 || bus.valid_o); i++) tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL drain_left got %0d expected 0", sb.size()); end
        checks++; if (bus.level_o !== 4'd0) begin errors++; $display("FAIL drain_level got %0d expected 0", bus.level_o); end
    endtask

    task automatic test_reset_mid();
        bus.ready_i = 1'b0;
        for (int k = 1; k <= 3; k++)
            drive_strobe(32'(k) << 15, 1'b1, 16'(k));
        tick();
        checks++; if (bus.level_o !== 4'd3) begin errors++; $display("FAIL rmid_pre_level got %0d expected 3", bus.level_o); end
        // Fourth result is in stage-1 when reset hits
        bus.valid_strobe_i = 1'b1;
        bus.y_i = 32'd4 << 15;
        tick();
        bus.valid_strobe_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b expected 0", bus.valid_o); end
        checks++; if (bus.level_o !== 4'd0) begin errors++; $display("FAIL rmid_level got %0d expected 0", bus.level_o); end
        sb.delete();
        tick();
        bus.valid_strobe_i = 1'b1;
        tick();
        rst = 1'b0;
        bus.ready_i = 1'b1;
        // A strobe held high across the release must not register as an event
        repeat (6) tick();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rmid_post_valid got %b expected 0", bus.valid_o); end
        checks++; if (bus.level_o !== 4'd0) begin errors++; $display("FAIL rmid_post_level got %0d expected 0", bus.level_o); end
        bus.valid_strobe_i = 1'b0;
        tick();
        drive_strobe(32'd5 << 15, 1'b1, 16'd5);
        repeat (3) tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rmid_after got %0d left expected 0", sb.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_rounding();
        test_back_to_back();
        test_overflow();
        test_full_pushpop_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
